// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode-stage, MEM/WB bypass and E-stage signals around the ID/EX operand stage.
// The slave modport is the stage itself; the master modport is whatever drives and observes it.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            StallE, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD;
  logic [REGW-1:0] Rs1D, Rs2D, RdD;
  logic [3:0]      ALUControlD;
  logic            ALUSrcAD, ALUSrcBD;
  logic            RegWriteD, MemWriteD, BranchD, JumpD, ValidD;
  logic [1:0]      ResultSrcD;
  logic [REGW-1:0] RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic [XLEN-1:0] ALUResultM, ResultW;
  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [3:0]      ALUControlE;
  logic [REGW-1:0] Rs1E, Rs2E, RdE;
  logic            RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
  logic [1:0]      ResultSrcE;
  logic [1:0]      ForwardAE, ForwardBE;

  modport slave (
    input  StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD,
           ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, BranchD, JumpD, ValidD, ResultSrcD,
           RdM, RdW, RegWriteM, RegWriteW, ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, BranchE, JumpE, ValidE, ResultSrcE, ForwardAE, ForwardBE
  );

  modport master (
    output StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD,
           ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, BranchD, JumpD, ValidD, ResultSrcD,
           RdM, RdW, RegWriteM, RegWriteW, ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, BranchE, JumpE, ValidE, ResultSrcE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus the EX operand network: MEM/WB bypass muxes and the
// ALU SrcA/SrcB selects, with store data always taken from the bypassed rs2.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic                    clk,
  input logic                    reset,
  id_ex_operand_stage_if.slave   io_bus
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [3:0]      alu_ctrl;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            valid;
    logic [1:0]      result_src;
  } e_fields_t;

  e_fields_t r_e;
  e_fields_t w_d;

  always_comb begin
    w_d            = '0;
    w_d.rd1        = io_bus.RD1D;
    w_d.rd2        = io_bus.RD2D;
    w_d.imm        = io_bus.ImmExtD;
    w_d.pc         = io_bus.PCD;
    w_d.rs1        = io_bus.Rs1D;
    w_d.rs2        = io_bus.Rs2D;
    w_d.rd         = io_bus.RdD;
    w_d.alu_ctrl   = io_bus.ALUControlD;
    w_d.alu_src_a  = io_bus.ALUSrcAD;
    w_d.alu_src_b  = io_bus.ALUSrcBD;
    w_d.reg_write  = io_bus.RegWriteD;
    w_d.mem_write  = io_bus.MemWriteD;
    w_d.branch     = io_bus.BranchD;
    w_d.jump       = io_bus.JumpD;
    w_d.valid      = io_bus.ValidD;
    w_d.result_src = io_bus.ResultSrcD;
  end

  // A bubble clears data as well as control, so a flushed slot feeds add 0+0.
  always_ff @(posedge clk) begin
    if (reset || io_bus.FlushE) begin
      r_e <= '0;
    end else if (!io_bus.StallE) begin
      r_e <= w_d;
    end
  end

  logic [REGW-1:0] w_rs      [2];
  logic [XLEN-1:0] w_rf_val  [2];
  logic [1:0]      w_fwd_sel [2];
  logic [XLEN-1:0] w_fwd_val [2];

  assign w_rs[0]     = r_e.rs1;
  assign w_rs[1]     = r_e.rs2;
  assign w_rf_val[0] = r_e.rd1;
  assign w_rf_val[1] = r_e.rd2;

  // MEM is checked before WB so the youngest producer wins; x0 never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        w_fwd_sel[gi] = 2'b00;
        if (io_bus.RegWriteM && (io_bus.RdM != '0) && (io_bus.RdM == w_rs[gi])) begin
          w_fwd_sel[gi] = 2'b10;
        end else if (io_bus.RegWriteW && (io_bus.RdW != '0) && (io_bus.RdW == w_rs[gi])) begin
          w_fwd_sel[gi] = 2'b01;
        end
      end

      always_comb begin
        w_fwd_val[gi] = w_rf_val[gi];
        case (w_fwd_sel[gi])
          2'b10:   w_fwd_val[gi] = io_bus.ALUResultM;
          2'b01:   w_fwd_val[gi] = io_bus.ResultW;
          default: w_fwd_val[gi] = w_rf_val[gi];
        endcase
      end
    end
  endgenerate

  assign io_bus.ForwardAE   = w_fwd_sel[0];
  assign io_bus.ForwardBE   = w_fwd_sel[1];
  assign io_bus.SrcAE       = r_e.alu_src_a ? r_e.pc  : w_fwd_val[0];
  assign io_bus.SrcBE       = r_e.alu_src_b ? r_e.imm : w_fwd_val[1];
  assign io_bus.WriteDataE  = w_fwd_val[1];
  assign io_bus.ALUControlE = r_e.alu_ctrl;
  assign io_bus.PCE         = r_e.pc;
  assign io_bus.ImmExtE     = r_e.imm;
  assign io_bus.Rs1E        = r_e.rs1;
  assign io_bus.Rs2E        = r_e.rs2;
  assign io_bus.RdE         = r_e.rd;
  assign io_bus.RegWriteE   = r_e.reg_write;
  assign io_bus.MemWriteE   = r_e.mem_write;
  assign io_bus.BranchE     = r_e.branch;
  assign io_bus.JumpE       = r_e.jump;
  assign io_bus.ValidE      = r_e.valid;
  assign io_bus.ResultSrcE  = r_e.result_src;

endmodule
